// File: rtl/uart_rx_cmd_if.sv
// rtl/uart_rx_cmd_if.sv - serial input and receive/command outputs of uart_rx_cmd
interface uart_rx_cmd_if;
  logic       i_Rx_Serial;
  logic       o_Rx_DV;
  logic [7:0] o_Rx_Byte;
  logic       o_frame_err;
  logic       o_parity_err;
  logic       o_cmd_query;
  logic [3:0] o_cmd_clear;
  logic       o_cmd_err;

  modport master (
    output i_Rx_Serial,
    input  o_Rx_DV, o_Rx_Byte, o_frame_err, o_parity_err,
    input  o_cmd_query, o_cmd_clear, o_cmd_err
  );

  modport slave (
    input  i_Rx_Serial,
    output o_Rx_DV, o_Rx_Byte, o_frame_err, o_parity_err,
    output o_cmd_query, o_cmd_clear, o_cmd_err
  );
endinterface

// File: rtl/uart_rx_cmd.sv
// rtl/uart_rx_cmd.sv - UART byte receiver with coin-counter command parser (RX_PARITY_EN adds even parity)
module uart_rx_cmd #(
  parameter int CLKS_PER_BIT = 87
) (
  input logic          clk,
  input logic          rst_n,
  uart_rx_cmd_if.slave bus
);

  localparam int            CW   = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, CLEANUP, WAIT_HIGH} rx_state_t;
  typedef enum logic {P_IDLE, P_CLR} p_state_t;

  logic          rx_meta;
  logic          rx_sync;
  rx_state_t     state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          rx_dv;
  logic [7:0]    rx_byte;
  logic          frame_err;
  logic          rx_err;
  p_state_t      pstate;
  logic          cmd_query;
  logic [3:0]    cmd_clear;
  logic          cmd_err;

`ifdef RX_PARITY_EN
  logic          par_bad;
  logic          parity_err;
  assign rx_err           = frame_err | parity_err;
  assign bus.o_parity_err = parity_err;
`else
  assign rx_err           = frame_err;
  assign bus.o_parity_err = 1'b0;
`endif

  assign bus.o_Rx_DV     = rx_dv;
  assign bus.o_Rx_Byte   = rx_byte;
  assign bus.o_frame_err = frame_err;
  assign bus.o_cmd_query = cmd_query;
  assign bus.o_cmd_clear = cmd_clear;
  assign bus.o_cmd_err   = cmd_err;

  // Two-flop synchronizer; resets to the idle-high line level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= bus.i_Rx_Serial;
      rx_sync <= rx_meta;
    end
  end

  // Receive FSM: mid-bit sampling, registered byte and error pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      rx_dv      <= 1'b0;
      rx_byte    <= 8'h00;
      frame_err  <= 1'b0;
`ifdef RX_PARITY_EN
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      rx_dv      <= 1'b0;
      frame_err  <= 1'b0;
`ifdef RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (!rx_sync) begin
            state <= START;
            cnt   <= '0;
`ifdef RX_PARITY_EN
            par_bad <= 1'b0;
`endif
          end
        end
        START: begin
          if (cnt == HALF) begin
            cnt <= '0;
            if (!rx_sync) begin
              state   <= DATA;
              bit_idx <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == LAST) begin
            cnt   <= '0;
            shreg <= {rx_sync, shreg[7:1]};
            if (bit_idx == 3'd7) begin
`ifdef RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef RX_PARITY_EN
        PARITY: begin
          if (cnt == LAST) begin
            cnt     <= '0;
            par_bad <= (rx_sync != ^shreg);
            state   <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          if (cnt == LAST) begin
            cnt <= '0;
            if (!rx_sync) begin
              frame_err <= 1'b1;
              state     <= WAIT_HIGH;
`ifdef RX_PARITY_EN
            end else if (par_bad) begin
              parity_err <= 1'b1;
              state      <= CLEANUP;
`endif
            end else begin
              rx_dv   <= 1'b1;
              rx_byte <= shreg;
              state   <= CLEANUP;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        CLEANUP: state <= IDLE;
        WAIT_HIGH: begin
          if (rx_sync) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Command parser: one pulse per completed command, one cycle after the byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pstate    <= P_IDLE;
      cmd_query <= 1'b0;
      cmd_clear <= 4'h0;
      cmd_err   <= 1'b0;
    end else begin
      cmd_query <= 1'b0;
      cmd_clear <= 4'h0;
      cmd_err   <= 1'b0;
      if (rx_dv) begin
        case (pstate)
          P_IDLE: begin
            if (rx_byte == 8'h51) begin
              cmd_query <= 1'b1;
            end else if (rx_byte == 8'h43) begin
              pstate <= P_CLR;
            end else if (rx_byte != 8'h0D && rx_byte != 8'h0A) begin
              cmd_err <= 1'b1;
            end
          end
          P_CLR: begin
            pstate <= P_IDLE;
            if (rx_byte >= 8'h30 && rx_byte <= 8'h33) begin
              cmd_clear <= 4'b0001 << rx_byte[1:0];
            end else if (rx_byte == 8'h41) begin
              cmd_clear <= 4'b1111;
            end else begin
              cmd_err <= 1'b1;
            end
          end
          default: pstate <= P_IDLE;
        endcase
      end else if (rx_err && pstate == P_CLR) begin
        pstate  <= P_IDLE;
        cmd_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_cmd.sv
// tb/tb_uart_rx_cmd.sv - randomized self-checking bench for uart_rx_cmd
module tb_uart_rx_cmd;

  localparam int CPB    = 8;
  localparam int K_NONE = 0;
  localparam int K_Q    = 1;
  localparam int K_ERR  = 2;
  localparam int K_CLR  = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  uart_rx_cmd_if bus();

  uart_rx_cmd #(.CLKS_PER_BIT(CPB)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int cyc = 0, n_dv = 0, n_ferr = 0, n_perr = 0, n_q = 0, n_err = 0, n_clr = 0, n_multi = 0;
  int dv_cyc = 0, ferr_cyc = 0, cmd_cyc = 0;
  logic [3:0] last_clr = 4'h0;
  bit model_pend = 0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (bus.o_Rx_DV)      begin n_dv   <= n_dv + 1;   dv_cyc   <= cyc; end
    if (bus.o_frame_err)  begin n_ferr <= n_ferr + 1; ferr_cyc <= cyc; end
    if (bus.o_parity_err) begin n_perr <= n_perr + 1; ferr_cyc <= cyc; end
    if (bus.o_cmd_query)  begin n_q    <= n_q + 1;    cmd_cyc  <= cyc; end
    if (bus.o_cmd_err)    begin n_err  <= n_err + 1;  cmd_cyc  <= cyc; end
    if (bus.o_cmd_clear != 4'h0) begin
      n_clr <= n_clr + 1; cmd_cyc <= cyc; last_clr <= bus.o_cmd_clear;
    end
    if (int'(bus.o_cmd_query) + int'(bus.o_cmd_err) + int'(bus.o_cmd_clear != 4'h0) > 1)
      n_multi <= n_multi + 1;
  end

  // Command meaning of one received byte given whether a 'C' is pending
  task automatic model_byte(input logic [7:0] b, output int kind, output logic [3:0] mask);
    mask = 4'h0;
    kind = K_NONE;
    if (model_pend) begin
      model_pend = 0;
      if (b >= 8'h30 && b <= 8'h33) begin
        kind = K_CLR; mask = 4'h1 << (b - 8'h30);
      end else if (b == 8'h41) begin
        kind = K_CLR; mask = 4'hF;
      end else kind = K_ERR;
    end else if (b == 8'h51) kind = K_Q;
    else if (b == 8'h43) model_pend = 1;
    else if (b != 8'h0D && b != 8'h0A) kind = K_ERR;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic bad_par);
    logic par;
    par = (^b) ^ bad_par;
    bus.i_Rx_Serial = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.i_Rx_Serial = b[i];
      repeat (CPB) @(negedge clk);
    end
`ifdef RX_PARITY_EN
    bus.i_Rx_Serial = par;
    repeat (CPB) @(negedge clk);
`endif
    bus.i_Rx_Serial = stop_bit;
    repeat (CPB) @(negedge clk);
    bus.i_Rx_Serial = 1'b1;
  endtask

  task automatic test_reset();
    bus.i_Rx_Serial = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (bus.o_Rx_DV !== 1'b0) begin bad++; $display("FAIL reset_dv got=%b exp=0", bus.o_Rx_DV); end
    total++; if (bus.o_Rx_Byte !== 8'h00) begin bad++; $display("FAIL reset_byte got=%h exp=00", bus.o_Rx_Byte); end
    total++; if (bus.o_frame_err !== 1'b0 || bus.o_parity_err !== 1'b0) begin bad++; $display("FAIL reset_errs got=%b%b exp=00", bus.o_frame_err, bus.o_parity_err); end
    total++; if (bus.o_cmd_query !== 1'b0 || bus.o_cmd_err !== 1'b0 || bus.o_cmd_clear !== 4'h0) begin
      bad++; $display("FAIL reset_cmd got=%b%b%h exp=000", bus.o_cmd_query, bus.o_cmd_err, bus.o_cmd_clear); end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  // Fixed command sequence followed by random bytes with short random gaps
  task automatic test_commands();
    logic [7:0] seq[$];
    logic [7:0] pick[10] = '{8'h51, 8'h43, 8'h30, 8'h31, 8'h32, 8'h33, 8'h41, 8'h58, 8'h0D, 8'h0A};
    int s_dv, s_ferr, s_perr, s_q, s_err, s_clr, kind, idx;
    logic [3:0] mask;
    seq = '{8'hA5, 8'h43, 8'h32, 8'h43, 8'h41, 8'h51, 8'h58, 8'h0D, 8'h0A};
    for (int i = 0; i < 16; i++) begin
      idx = $urandom_range(0, 10);
      seq.push_back(idx == 10 ? 8'($urandom) : pick[idx]);
    end
    foreach (seq[i]) begin
      s_dv = n_dv; s_ferr = n_ferr; s_perr = n_perr; s_q = n_q; s_err = n_err; s_clr = n_clr;
      model_byte(seq[i], kind, mask);
      send_frame(seq[i], 1'b1, 1'b0);
      repeat (3) @(negedge clk);
      total++; if (n_dv - s_dv !== 1) begin bad++; $display("FAIL cmd_dv[%0d] got=%0d exp=1", i, n_dv - s_dv); end
      total++; if (bus.o_Rx_Byte !== seq[i]) begin bad++; $display("FAIL cmd_byte[%0d] got=%h exp=%h", i, bus.o_Rx_Byte, seq[i]); end
      total++; if (n_ferr != s_ferr || n_perr != s_perr) begin bad++; $display("FAIL cmd_noerr[%0d] got=%0d/%0d exp=0/0", i, n_ferr - s_ferr, n_perr - s_perr); end
      total++; if (n_q - s_q !== (kind == K_Q ? 1 : 0)) begin bad++; $display("FAIL cmd_query[%0d] got=%0d kind=%0d", i, n_q - s_q, kind); end
      total++; if (n_err - s_err !== (kind == K_ERR ? 1 : 0)) begin bad++; $display("FAIL cmd_err[%0d] got=%0d kind=%0d", i, n_err - s_err, kind); end
      total++; if (n_clr - s_clr !== (kind == K_CLR ? 1 : 0)) begin bad++; $display("FAIL cmd_clr_cnt[%0d] got=%0d kind=%0d", i, n_clr - s_clr, kind); end
      if (kind == K_CLR) begin
        total++; if (last_clr !== mask) begin bad++; $display("FAIL cmd_clr_mask[%0d] got=%b exp=%b", i, last_clr, mask); end
      end
      if (kind != K_NONE) begin
        total++; if (cmd_cyc !== dv_cyc + 1) begin bad++; $display("FAIL cmd_latency[%0d] got=%0d exp=1", i, cmd_cyc - dv_cyc); end
      end
      repeat ($urandom_range(0, 6)) @(negedge clk);
    end
  endtask

  task automatic test_glitch();
    int s_dv, s_ferr, s_q, s_err, s_clr, kind;
    logic [3:0] mask;
    s_dv = n_dv; s_ferr = n_ferr; s_q = n_q; s_err = n_err; s_clr = n_clr;
    bus.i_Rx_Serial = 1'b0;
    repeat (3) @(negedge clk);
    bus.i_Rx_Serial = 1'b1;
    repeat (20) @(negedge clk);
    total++; if (n_dv != s_dv || n_ferr != s_ferr || n_q != s_q || n_err != s_err || n_clr != s_clr) begin
      bad++; $display("FAIL glitch_quiet dv=%0d ferr=%0d q=%0d err=%0d clr=%0d exp=all0", n_dv - s_dv, n_ferr - s_ferr, n_q - s_q, n_err - s_err, n_clr - s_clr); end
    model_byte(8'h51, kind, mask);
    send_frame(8'h51, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    total++; if (n_dv - s_dv !== 1) begin bad++; $display("FAIL glitch_next_dv got=%0d exp=1", n_dv - s_dv); end
    total++; if (n_q - s_q !== (kind == K_Q ? 1 : 0)) begin bad++; $display("FAIL glitch_next_query got=%0d kind=%0d", n_q - s_q, kind); end
  endtask

  task automatic test_break();
    int s_dv, s_ferr, s_err, kind;
    logic [3:0] mask;
    model_byte(8'h43, kind, mask);
    send_frame(8'h43, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    s_dv = n_dv; s_ferr = n_ferr; s_err = n_err;
    // framing error while 'C' is pending cancels the command
    model_pend = 0;
    send_frame(8'h55, 1'b0, 1'b0);
    bus.i_Rx_Serial = 1'b0;
    repeat (40) @(negedge clk);
    bus.i_Rx_Serial = 1'b1;
    repeat (20) @(negedge clk);
    total++; if (n_ferr - s_ferr !== 1) begin bad++; $display("FAIL break_ferr got=%0d exp=1", n_ferr - s_ferr); end
    total++; if (n_dv != s_dv) begin bad++; $display("FAIL break_dv got=%0d exp=0", n_dv - s_dv); end
    total++; if (bus.o_Rx_Byte !== 8'h43) begin bad++; $display("FAIL break_byte got=%h exp=43", bus.o_Rx_Byte); end
    total++; if (n_err - s_err !== 1) begin bad++; $display("FAIL break_cmd_err got=%0d exp=1", n_err - s_err); end
    total++; if (cmd_cyc !== ferr_cyc + 1) begin bad++; $display("FAIL break_err_latency got=%0d exp=1", cmd_cyc - ferr_cyc); end
    s_err = n_err;
    model_byte(8'h31, kind, mask);
    send_frame(8'h31, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    total++; if (n_dv - s_dv !== 1 || bus.o_Rx_Byte !== 8'h31) begin bad++; $display("FAIL break_next got=%0d/%h exp=1/31", n_dv - s_dv, bus.o_Rx_Byte); end
    total++; if (n_err - s_err !== (kind == K_ERR ? 1 : 0)) begin bad++; $display("FAIL break_next_err got=%0d kind=%0d", n_err - s_err, kind); end
  endtask

  task automatic test_reset_mid_frame();
    int s_dv, s_ferr, s_q, s_err, s_clr, kind;
    logic [3:0] mask;
    model_byte(8'h43, kind, mask);
    send_frame(8'h43, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    bus.i_Rx_Serial = 1'b0;
    repeat (30) @(negedge clk);
    rst_n = 1'b0;
    model_pend = 0;
    repeat (2) @(negedge clk);
    total++; if (bus.o_Rx_DV !== 1'b0 || bus.o_Rx_Byte !== 8'h00 || bus.o_frame_err !== 1'b0 || bus.o_parity_err !== 1'b0) begin
      bad++; $display("FAIL midrst_rx got=%b/%h/%b%b exp=0/00/00", bus.o_Rx_DV, bus.o_Rx_Byte, bus.o_frame_err, bus.o_parity_err); end
    total++; if (bus.o_cmd_query !== 1'b0 || bus.o_cmd_err !== 1'b0 || bus.o_cmd_clear !== 4'h0) begin
      bad++; $display("FAIL midrst_cmd got=%b%b%h exp=000", bus.o_cmd_query, bus.o_cmd_err, bus.o_cmd_clear); end
    bus.i_Rx_Serial = 1'b1;
    s_dv = n_dv; s_ferr = n_ferr; s_q = n_q; s_err = n_err; s_clr = n_clr;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    total++; if (n_dv != s_dv || n_ferr != s_ferr || n_q != s_q || n_err != s_err || n_clr != s_clr) begin
      bad++; $display("FAIL midrst_quiet dv=%0d ferr=%0d err=%0d exp=0", n_dv - s_dv, n_ferr - s_ferr, n_err - s_err); end
    model_byte(8'h31, kind, mask);
    send_frame(8'h31, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    total++; if (n_dv - s_dv !== 1 || bus.o_Rx_Byte !== 8'h31) begin bad++; $display("FAIL midrst_next got=%0d/%h exp=1/31", n_dv - s_dv, bus.o_Rx_Byte); end
    total++; if (n_err - s_err !== (kind == K_ERR ? 1 : 0)) begin bad++; $display("FAIL midrst_next_err got=%0d kind=%0d", n_err - s_err, kind); end
    total++; if (n_clr != s_clr) begin bad++; $display("FAIL midrst_no_clear got=%0d exp=0", n_clr - s_clr); end
  endtask

  task automatic test_parity();
`ifdef RX_PARITY_EN
    int s_dv, s_ferr, s_perr, s_err;
    logic [7:0] prev;
    bit pend_before;
    prev = bus.o_Rx_Byte;
    pend_before = model_pend;
    model_pend = 0;
    s_dv = n_dv; s_ferr = n_ferr; s_perr = n_perr; s_err = n_err;
    send_frame(8'h3C, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    total++; if (n_perr - s_perr !== 1) begin bad++; $display("FAIL parity_err got=%0d exp=1", n_perr - s_perr); end
    total++; if (n_dv != s_dv || n_ferr != s_ferr) begin bad++; $display("FAIL parity_only got=%0d/%0d exp=0/0", n_dv - s_dv, n_ferr - s_ferr); end
    total++; if (bus.o_Rx_Byte !== prev) begin bad++; $display("FAIL parity_byte got=%h exp=%h", bus.o_Rx_Byte, prev); end
    total++; if (n_err - s_err !== (pend_before ? 1 : 0)) begin bad++; $display("FAIL parity_cmd_err got=%0d exp=%0d", n_err - s_err, pend_before); end
`else
    total++; if (n_perr !== 0) begin bad++; $display("FAIL parity_tied got=%0d exp=0", n_perr); end
`endif
  endtask

  task automatic test_exclusive();
    total++; if (n_multi !== 0) begin bad++; $display("FAIL cmd_exclusive got=%0d exp=0", n_multi); end
  endtask

  initial begin
    test_reset();
    test_commands();
    test_glitch();
    test_break();
    test_reset_mid_frame();
    test_parity();
    test_commands();
    test_exclusive();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
